// File: rtl/alu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : alu_seq                                                |
// | Description : Accumulator/flag sequencer in front of the 8-bit ALU.  |
// |               Accepts one command per valid/ready handshake, drives  |
// |               the ALU from registered state and writes the result    |
// |               and flags back into A and F. LDA/STC/CMC run locally.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_seq #(
    parameter int DATASIZE = 8,
    parameter int CARRY_F  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [2:0]          cmd,
    input  logic [DATASIZE-1:0] cmd_data,
    output logic                cmd_ready,
    output logic                done,
    output logic [DATASIZE-1:0] acc,
    output logic [DATASIZE-1:0] flags,
    output logic [1:0]          alu_op,
    output logic [DATASIZE-1:0] alu_a,
    output logic [DATASIZE-1:0] alu_b,
    output logic [DATASIZE-1:0] alu_f,
    input  logic [DATASIZE-1:0] alu_r,
    input  logic [DATASIZE-1:0] alu_fo
);

    // Command codes
    localparam logic [2:0] c_ADC = 3'b000;
    localparam logic [2:0] c_ACI = 3'b001;
    localparam logic [2:0] c_SBB = 3'b010;
    localparam logic [2:0] c_ANA = 3'b011;
    localparam logic [2:0] c_CMP = 3'b100;
    localparam logic [2:0] c_LDA = 3'b101;
    localparam logic [2:0] c_STC = 3'b110;
    localparam logic [2:0] c_CMC = 3'b111;

    // ALU operation codes
    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SBB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;
    localparam logic [1:0] c_OP_CMP = 2'b11;

    // Sequencer states
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [DATASIZE-1:0] r_acc;
    logic [DATASIZE-1:0] r_flags;
    logic [DATASIZE-1:0] r_tmp;
    logic [2:0]          r_cmd_q;
    logic                w_cmd_ready;
    logic                w_done;
    logic                w_accept;
    logic [1:0]          w_alu_op;

    assign w_accept = cmd_valid & w_cmd_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = c_S_EXEC;
                end
            end
            c_S_EXEC: begin
                w_state_nxt = c_S_DONE;
            end
            c_S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Command/operand capture on accept; write-back at the closing edge of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_q <= 3'b000;
            r_tmp   <= '0;
            r_acc   <= '0;
            r_flags <= '0;
        end else begin
            if (w_accept) begin
                r_cmd_q <= cmd;
                r_tmp   <= cmd_data;
            end
            if (r_state == c_S_EXEC) begin
                case (r_cmd_q)
                    c_ADC, c_ACI, c_SBB, c_ANA: begin
                        r_acc   <= alu_r;
                        r_flags <= alu_fo;
                    end
                    c_CMP: begin
                        r_flags <= alu_fo;
                    end
                    c_LDA: begin
                        r_acc <= r_tmp;
                    end
                    c_STC: begin
                        r_flags[CARRY_F] <= 1'b1;
                    end
                    c_CMC: begin
                        r_flags[CARRY_F] <= ~r_flags[CARRY_F];
                    end
                    default: begin
                        r_acc <= r_acc;
                    end
                endcase
            end
        end
    end

    // ALU opcode decoded straight from the latched command
    always_comb begin
        w_alu_op = c_OP_ADD;
        case (r_cmd_q)
            c_ADC, c_ACI: w_alu_op = c_OP_ADD;
            c_SBB:        w_alu_op = c_OP_SBB;
            c_ANA:        w_alu_op = c_OP_AND;
            c_CMP:        w_alu_op = c_OP_CMP;
            default:      w_alu_op = c_OP_ADD;
        endcase
    end

    assign cmd_ready = w_cmd_ready;
    assign done      = w_done;
    assign acc       = r_acc;
    assign flags     = r_flags;
    assign alu_op    = w_alu_op;
    assign alu_a     = r_acc;
    assign alu_b     = r_tmp;
    assign alu_f     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_alu_seq                                             |
// | Description : Directed bench for alu_seq with a behavioural 8-bit    |
// |               ALU attached (flags: S Z 0 AC 0 P 0 CY).               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_seq;

    localparam logic [2:0] c_ADC = 3'b000;
    localparam logic [2:0] c_ACI = 3'b001;
    localparam logic [2:0] c_SBB = 3'b010;
    localparam logic [2:0] c_ANA = 3'b011;
    localparam logic [2:0] c_CMP = 3'b100;
    localparam logic [2:0] c_LDA = 3'b101;
    localparam logic [2:0] c_STC = 3'b110;
    localparam logic [2:0] c_CMC = 3'b111;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       done;
    logic [7:0] acc;
    logic [7:0] flags;
    logic [1:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_f;
    logic [7:0] alu_r;
    logic [7:0] alu_fo;

    int n_tests;
    int n_fail;

    alu_seq #(
        .DATASIZE(8),
        .CARRY_F (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .cmd_data (cmd_data),
        .cmd_ready(cmd_ready),
        .done     (done),
        .acc      (acc),
        .flags    (flags),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_f    (alu_f),
        .alu_r    (alu_r),
        .alu_fo   (alu_fo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 00 add-with-carry, 01 sub-with-borrow, 10 and (AC passes through), 11 compare
    logic [8:0] w_full;
    logic [4:0] w_half;
    logic       w_ac;
    always_comb begin
        w_full = 9'd0;
        w_half = 5'd0;
        w_ac   = 1'b0;
        case (alu_op)
            2'b00: begin
                w_full = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_f[0]};
                w_half = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, alu_f[0]};
                w_ac   = w_half[4];
            end
            2'b01: begin
                w_full = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_f[0]};
                w_half = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'd0, alu_f[0]};
                w_ac   = w_half[4];
            end
            2'b10: begin
                w_full = {1'b0, alu_a & alu_b};
                w_ac   = alu_f[4];
            end
            default: begin
                w_full = {1'b0, alu_a} - {1'b0, alu_b};
                w_half = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]};
                w_ac   = w_half[4];
            end
        endcase
        alu_r  = w_full[7:0];
        alu_fo = {w_full[7], (w_full[7:0] == 8'd0), 1'b0, w_ac, 1'b0, ~^w_full[7:0], 1'b0, w_full[8]};
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // One full command: accept in IDLE, probe EXEC, check results in DONE
    task automatic run_cmd(input string tag, input logic [2:0] c, input logic [7:0] d,
                           input logic [1:0] exp_op, input logic [7:0] exp_acc,
                           input logic [7:0] exp_flags);
        @(negedge clk);
        check({tag, ".ready_idle"}, {7'd0, cmd_ready}, 8'd1);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = ~d;
        check({tag, ".ready_exec"}, {7'd0, cmd_ready}, 8'd0);
        check({tag, ".done_exec"}, {7'd0, done}, 8'd0);
        check({tag, ".alu_op"}, {6'd0, alu_op}, {6'd0, exp_op});
        check({tag, ".alu_b"}, alu_b, d);
        @(negedge clk);
        check({tag, ".done"}, {7'd0, done}, 8'd1);
        check({tag, ".acc"}, acc, exp_acc);
        check({tag, ".flags"}, flags, exp_flags);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 3'b000;
        cmd_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.acc", acc, 8'h00);
        check("rst.flags", flags, 8'h00);
        check("rst.ready", {7'd0, cmd_ready}, 8'd1);
        check("rst.done", {7'd0, done}, 8'd0);
        check("rst.alu_op", {6'd0, alu_op}, 8'd0);
        check("rst.alu_a", alu_a, 8'h00);
        check("rst.alu_b", alu_b, 8'h00);
        check("rst.alu_f", alu_f, 8'h00);
        rst = 1'b0;

        // 3A + C6 + 0 = 100: Z, AC, P, CY -> 55
        run_cmd("lda3a", c_LDA, 8'h3A, 2'b00, 8'h3A, 8'h00);
        run_cmd("adc", c_ADC, 8'hC6, 2'b00, 8'h00, 8'h55);

        // 10 - 20 = F0: S, P (even), CY (borrow) -> 85; acc untouched
        run_cmd("lda10", c_LDA, 8'h10, 2'b00, 8'h10, 8'h55);
        run_cmd("cmp", c_CMP, 8'h20, 2'b11, 8'h10, 8'h85);

        // Flag-only ops from a clean flag register
        do_reset();
        run_cmd("lda5a", c_LDA, 8'h5A, 2'b00, 8'h5A, 8'h00);
        run_cmd("stc", c_STC, 8'hFF, 2'b00, 8'h5A, 8'h01);
        run_cmd("cmc1", c_CMC, 8'hFF, 2'b00, 8'h5A, 8'h00);
        run_cmd("cmc2", c_CMC, 8'h00, 2'b00, 8'h5A, 8'h01);

        // 05 - 02 - 1 = 02, no borrow, odd parity -> flags 00
        run_cmd("lda05", c_LDA, 8'h05, 2'b00, 8'h05, 8'h01);
        run_cmd("sbb", c_SBB, 8'h02, 2'b01, 8'h02, 8'h00);

        // 0F + 01 = 10 sets AC only -> 10; ANA must carry that AC through
        run_cmd("lda0f", c_LDA, 8'h0F, 2'b00, 8'h0F, 8'h00);
        run_cmd("aci", c_ACI, 8'h01, 2'b00, 8'h10, 8'h10);
        run_cmd("ldaf2", c_LDA, 8'hF2, 2'b00, 8'hF2, 8'h10);
        run_cmd("ana", c_ANA, 8'h0F, 2'b10, 8'h02, 8'h10);

        // Held cmd_valid with operand changing outside IDLE
        @(negedge clk);
        check("hs.ready0", {7'd0, cmd_ready}, 8'd1);
        cmd_valid = 1'b1;
        cmd       = c_LDA;
        cmd_data  = 8'h11;
        @(negedge clk);
        check("hs.ready1", {7'd0, cmd_ready}, 8'd0);
        cmd_data = 8'h22;
        @(negedge clk);
        check("hs.ready2", {7'd0, cmd_ready}, 8'd0);
        check("hs.done1", {7'd0, done}, 8'd1);
        check("hs.acc1", acc, 8'h11);
        cmd_data = 8'h33;
        @(negedge clk);
        check("hs.ready3", {7'd0, cmd_ready}, 8'd1);
        check("hs.done_idle", {7'd0, done}, 8'd0);
        cmd_data = 8'h44;
        @(negedge clk);
        check("hs.ready4", {7'd0, cmd_ready}, 8'd0);
        cmd_data = 8'h55;
        @(negedge clk);
        check("hs.done2", {7'd0, done}, 8'd1);
        check("hs.acc2", acc, 8'h44);
        cmd_valid = 1'b0;

        // Reset during EXEC of ADC 01 with acc=FF aborts the write-back
        run_cmd("ldaff", c_LDA, 8'hFF, 2'b00, 8'hFF, 8'h10);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c_ADC;
        cmd_data  = 8'h01;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mr.exec_ready", {7'd0, cmd_ready}, 8'd0);
        rst = 1'b1;
        #1;
        check("mr.acc", acc, 8'h00);
        check("mr.flags", flags, 8'h00);
        check("mr.ready", {7'd0, cmd_ready}, 8'd1);
        check("mr.done", {7'd0, done}, 8'd0);
        @(negedge clk);
        check("mr.done_hold", {7'd0, done}, 8'd0);
        check("mr.acc_hold", acc, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("mr.done_after", {7'd0, done}, 8'd0);

        // Normal operation resumes after reset
        run_cmd("post", c_LDA, 8'h77, 2'b00, 8'h77, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Accumulator/flag sequencer sitting directly upstream of the 8-bit ALU. It accepts one arithmetic/logic command at a time over a valid/ready handshake and holds the operand in a temp register. It drives the ALU's op, operand and flag-in lines from registered state, then writes the ALU result and flags back into the architectural accumulator (A) and flag register (F). It also executes the non-ALU commands LDA, STC and CMC locally.

## Interface
- DATASIZE, 8, data/accumulator width; must match the ALU.
- CARRY_F, 0, carry bit index in F.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd  in  3  command code: 000 ADC, 001 ACI, 010 SBB, 011 ANA, 100 CMP, 101 LDA, 110 STC, 111 CMC.
- cmd_data  in  DATASIZE  operand (register value or immediate).
- cmd_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse: command retired, A/F updated.
- acc  out  DATASIZE  accumulator register.
- flags  out  DATASIZE  flag register.
- alu_op  out  2  to ALU alu_op: 00 add, 01 sub-with-borrow, 10 and, 11 compare.
- alu_a / alu_b / alu_f  out  DATASIZE each  to ALU iA/iB/iF; driven by acc, tmp and flags.
- alu_r / alu_fo  in  DATASIZE each  from ALU oR/oF.

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Registers: acc, flags, tmp, cmd_q (3 b), state.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_q←cmd and tmp←cmd_data, then go to EXEC.
  - EXEC: ALU inputs are stable all cycle. At the closing edge, write back per cmd_q and go to DONE.
  - DONE: done=1. Unconditionally return to IDLE.
- Op mapping from cmd_q to alu_op: ADC/ACI→00, SBB→01, ANA→10, CMP→11, all others→00. The value is combinational from cmd_q.
- Operand wiring: alu_a=acc, alu_b=tmp, alu_f=flags.
- Write-back in EXEC:
  - ADC, ACI, SBB, ANA: acc←alu_r, flags←alu_fo.
  - CMP: flags←alu_fo; acc unchanged.
  - LDA: acc←tmp; flags unchanged.
  - STC: flags[CARRY_F]←1; other flag bits unchanged; acc unchanged.
  - CMC: flags[CARRY_F]←~flags[CARRY_F]; rest unchanged.
- Flags are stored exactly as the ALU returns them, including bits 1/3/5=0. For ANA the ALU passes AC through from alu_f.
- Arithmetic width: no internal arithmetic except the CMC inversion. Carry/borrow come from alu_fo[CARRY_F].
- cmd_valid and cmd/cmd_data are ignored outside IDLE. A held cmd_valid is accepted again in the next IDLE as a new command.

## Timing
- Reset values: state=IDLE, acc=0, flags=0, tmp=0, cmd_q=000, cmd_ready=1 (state-derived), done=0, alu_op=00, alu_a/alu_b/alu_f=0.
- Command accepted at edge N (cmd_valid & cmd_ready):
  - EXEC during cycle N→N+1.
  - A/F updated at edge N+1.
  - done=1 and new acc/flags visible during cycle N+1→N+2.
  - cmd_ready=1 again after edge N+2.
- Latency is 2 cycles from accept to done; throughput is 1 command per 3 cycles.
- ALU path is combinational within EXEC (one-cycle path: regs→ALU→regs).
- Reset asserted in any state (including EXEC, before the write edge):
  - Immediately forces the reset values.
  - No partial write-back; done never pulses for the aborted command.
- Reset deassertion: the first accept is possible at the first rising edge where rst=0 and cmd_valid=1.
- Simultaneous events: none possible besides reset, which always wins.

## Test plan
- Reset, then ADC (cmd=000): LDA 0x3A, then ADC cmd_data=0xC6, carry=0 → acc=0x00, flags=0x55 (Z, AC, P, CY set); done exactly 2 cycles after the ADC accept.
- CMP: LDA 0x10, then CMP 0x20 → acc stays 0x10, flags[CARRY_F]=1, flags[7]=1, flags[6]=0.
- Flag-only ops, from flags=0x00: STC → flags=0x01; CMC → 0x00; CMC → 0x01; acc unchanged throughout.
- SBB: flags CY=1, acc=0x05, SBB 0x02 → acc=0x02, CY=0; then ANA 0x0F with acc=0xF2 → acc=0x02, CY=0, AC equal to the prior AC.
- Handshake: hold cmd_valid=1 with a changing cmd_data during EXEC/DONE → only the IDLE-sampled value is used; cmd_ready pattern is 1,0,0,1; back-to-back commands are spaced 3 cycles.
- Mid-operation reset: assert rst in EXEC of ADC 0x01 with acc=0xFF → acc=0, flags=0, done stays 0, state IDLE, cmd_ready=1 during reset.
